uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
//
// PURPOSE
// Shares a single uart_tx transmitter between NUM_REQ byte producers
// (e.g. CPU console, debug/trace unit, boot messages).
// Arbitrates round-robin, then sequences one byte per grant into uart_tx:
// captures the data, pulses uart_tx_en, and waits for uart_tx_busy to rise and fall.
// Sits between the requesters and the uart_tx instance in the UART subsystem.
//
// PARAMETERS
// NUM_REQ       4   Number of requesters; legal range 2..16.
// PAYLOAD_BITS  8   Byte width; must equal the uart_tx PAYLOAD_BITS.
// IDW           $clog2(NUM_REQ)   localparam; width of grant_id.
//
// PORTS
// clk           in   1                     System clock.
// resetn        in   1                     Asynchronous active-low reset.
// req_valid     in   NUM_REQ               Per-requester byte valid.
// req_data      in   NUM_REQ*PAYLOAD_BITS  Requester i owns bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
// req_last      in   NUM_REQ               Last byte of a packet; used only with the lock option.
// req_ready     out  NUM_REQ               One-hot accept pulse.
// grant_id      out  IDW                   Index of the current or most recent grantee.
// uart_tx_en    out  1                     Send strobe to uart_tx.
// uart_tx_data  out  PAYLOAD_BITS          Byte to uart_tx; valid while uart_tx_en=1.
// uart_tx_busy  in   1                     Busy flag from uart_tx.
//
// BEHAVIOUR
// - All outputs are registered.
// - Reset values: req_ready=0, uart_tx_en=0, uart_tx_data=0, grant_id=0,
//   state=IDLE, round-robin pointer last=NUM_REQ-1.
// - Reset assertion aborts any state immediately. A byte already handed to
//   uart_tx is not recalled; a byte in GRANT is lost.
// - Handshake: a requester holds req_valid and req_data stable until it sees
//   req_ready. The transfer occurs in the cycle req_valid & req_ready.
// - FSM:
//   - IDLE: if |req_valid and !uart_tx_busy, then
//     g = first i with req_valid[i], searching from last+1 and wrapping modulo NUM_REQ.
//     Register grant_id=g, last=g; go to GRANT. Otherwise stay in IDLE.
//   - GRANT (1 cycle): req_ready[g]=1; uart_tx_data <= req_data[g]; go to ISSUE.
//   - ISSUE (1 cycle): uart_tx_en=1; go to WAIT_BUSY.
//   - WAIT_BUSY: uart_tx_busy=1 -> WAIT_DONE.
//     If busy is not seen within 2 cycles -> IDLE (lost strobe; no retry).
//   - WAIT_DONE: uart_tx_busy=0 -> IDLE.
// - Latency: valid sampled in IDLE at cycle t gives req_ready at t+1 and uart_tx_en at t+2.
//   The next grant can be decided in the first IDLE cycle after busy falls.
// - req_valid dropping while the FSM is not in IDLE has no effect
//   (this is a protocol violation if it happens before ready).
//   The sampled grantee has valid held by rule.
// - Only one byte is in flight at a time, so there is no buffering.
//   uart_tx_data holds its value until the next GRANT.
//
// CONFIGURATION
// UART_TX_ARBITER_LOCK_EN:
// - Defined: packet lock.
//   - A grant to g with req_last[g]=0 sets locked=1.
//   - While locked, IDLE considers only requester g.
//   - Others wait even if valid; g need not be valid and the FSM waits for it.
//   - locked clears when a byte with req_last[g]=1 is accepted, or on reset.
//   - last is updated only when a packet ends.
// - Undefined: req_last is ignored; arbitration rotates after every byte.
//
// TESTING
// 1. After reset, req_valid=4'b0100, req_data[2]=0xA5, busy modelled by real uart_tx
//    -> req_ready=4'b0100 for 1 cycle at t+1; uart_tx_en at t+2 with data 0xA5; grant_id=2.
// 2. All four valid and held, each re-asserted after ready -> grant order 0,1,2,3,0,1;
//    exactly one uart_tx_en per busy window.
// 3. uart_tx_busy forced high, req_valid[1]=1 -> no req_ready until busy goes low;
//    grant occurs in the first IDLE cycle after busy falls.
// 4. Assert resetn=0 during WAIT_DONE -> all outputs 0 immediately.
//    After release, with requesters 0 and 3 valid, the first grant is 0.
// 5. LOCK_EN: req1 sends 3 bytes with last on the 3rd, req0 valid throughout
//    -> order 1,1,1,0. Without the macro -> order 1,0,1,0,1.
// 6. busy held low (uart_tx stub ignores en) -> FSM returns to IDLE 2 cycles after ISSUE;
//    the next requester is granted.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart_tx side signals of the shared-transmitter arbiter.
// master = requesters plus the uart_tx busy flag; slave = the arbiter itself.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ      = 4,
   parameter int PAYLOAD_BITS = 8
);
   localparam int IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]              req_valid;
   logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data;
   logic [NUM_REQ-1:0]              req_last;
   logic [NUM_REQ-1:0]              req_ready;
   logic [IDW-1:0]                  grant_id;
   logic                            uart_tx_en;
   logic [PAYLOAD_BITS-1:0]         uart_tx_data;
   logic                            uart_tx_busy;

   modport master (
      output req_valid, req_data, req_last, uart_tx_busy,
      input  req_ready, grant_id, uart_tx_en, uart_tx_data
   );

   modport slave (
      input  req_valid, req_data, req_last, uart_tx_busy,
      output req_ready, grant_id, uart_tx_en, uart_tx_data
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers, one byte per grant.
// Optional packet lock (hold the grant until req_last) enabled by defining UART_TX_ARBITER_LOCK_EN.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int PAYLOAD_BITS = 8
) (
   input logic               i_clk,
   input logic               i_resetn,
   uart_tx_arbiter_if.slave  bus
);
   localparam int IDW = $clog2(NUM_REQ);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_t;

   state_t                  r_state;
   state_t                  w_stateNext;
   logic [IDW-1:0]          r_last;
   logic [IDW-1:0]          w_lastNext;
   logic [IDW-1:0]          r_grant;
   logic [IDW-1:0]          w_grantNext;
   logic [NUM_REQ-1:0]      r_ready;
   logic [NUM_REQ-1:0]      w_readyNext;
   logic                    r_en;
   logic                    w_enNext;
   logic [PAYLOAD_BITS-1:0] r_data;
   logic [PAYLOAD_BITS-1:0] w_dataNext;
   logic                    r_waitCnt;
   logic                    w_waitCntNext;
   logic [IDW-1:0]          w_pick;
   logic                    w_pickValid;
   logic [IDW-1:0]          w_idxNarrow;
   int                      w_idx;
`ifdef UART_TX_ARBITER_LOCK_EN
   logic                    r_locked;
   logic                    w_lockedNext;
`else
   logic                    w_unused_last;
   assign w_unused_last = ^bus.req_last;
`endif

   // Walk downward so the requester closest after r_last is the one left standing.
   always_comb begin
      w_idx       = 0;
      w_idxNarrow = '0;
      w_pick      = '0;
      w_pickValid = 1'b0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         w_idx = int'(r_last) + k;
         if (w_idx >= NUM_REQ) begin
            w_idx = w_idx - NUM_REQ;
         end
         w_idxNarrow = IDW'(w_idx);
         if (bus.req_valid[w_idxNarrow]) begin
            w_pick      = w_idxNarrow;
            w_pickValid = 1'b1;
         end
      end
`ifdef UART_TX_ARBITER_LOCK_EN
      if (r_locked) begin
         w_pick      = r_grant;
         w_pickValid = bus.req_valid[r_grant];
      end
`endif
   end

   always_comb begin
      w_stateNext   = r_state;
      w_lastNext    = r_last;
      w_grantNext   = r_grant;
      w_readyNext   = '0;
      w_enNext      = 1'b0;
      w_dataNext    = r_data;
      w_waitCntNext = r_waitCnt;
`ifdef UART_TX_ARBITER_LOCK_EN
      w_lockedNext  = r_locked;
`endif
      case (r_state)
         S_IDLE: begin
            w_waitCntNext = 1'b0;
            if (w_pickValid && !bus.uart_tx_busy) begin
               w_grantNext         = w_pick;
               w_readyNext[w_pick] = 1'b1;
`ifndef UART_TX_ARBITER_LOCK_EN
               w_lastNext          = w_pick;
`endif
               w_stateNext         = S_GRANT;
            end
         end
         S_GRANT: begin
            w_dataNext  = bus.req_data[r_grant*PAYLOAD_BITS +: PAYLOAD_BITS];
            w_enNext    = 1'b1;
            w_stateNext = S_ISSUE;
`ifdef UART_TX_ARBITER_LOCK_EN
            // Rotation only advances once the whole packet has gone out.
            if (bus.req_last[r_grant]) begin
               w_lockedNext = 1'b0;
               w_lastNext   = r_grant;
            end else begin
               w_lockedNext = 1'b1;
            end
`endif
         end
         S_ISSUE: begin
            w_stateNext = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            // A strobe uart_tx never acknowledged is dropped rather than retried.
            if (bus.uart_tx_busy) begin
               w_stateNext = S_WAIT_DONE;
            end else if (r_waitCnt) begin
               w_stateNext = S_IDLE;
            end else begin
               w_waitCntNext = 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (!bus.uart_tx_busy) begin
               w_stateNext = S_IDLE;
            end
         end
         default: begin
            w_stateNext = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state   <= S_IDLE;
         r_last    <= IDW'(NUM_REQ - 1);
         r_grant   <= '0;
         r_ready   <= '0;
         r_en      <= 1'b0;
         r_data    <= '0;
         r_waitCnt <= 1'b0;
`ifdef UART_TX_ARBITER_LOCK_EN
         r_locked  <= 1'b0;
`endif
      end else begin
         r_state   <= w_stateNext;
         r_last    <= w_lastNext;
         r_grant   <= w_grantNext;
         r_ready   <= w_readyNext;
         r_en      <= w_enNext;
         r_data    <= w_dataNext;
         r_waitCnt <= w_waitCntNext;
`ifdef UART_TX_ARBITER_LOCK_EN
         r_locked  <= w_lockedNext;
`endif
      end
   end

   assign bus.req_ready    = r_ready;
   assign bus.grant_id     = r_grant;
   assign bus.uart_tx_en   = r_en;
   assign bus.uart_tx_data = r_data;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester models, a uart_tx busy stub and an
// expected-byte queue checked at every uart_tx_en. Expected orders follow UART_TX_ARBITER_LOCK_EN.
module tb_uart_tx_arbiter;
   localparam int NUM_REQ  = 4;
   localparam int PB       = 8;
   localparam int BUSY_CYC = 6;

   typedef struct {
      int         id;
      logic [7:0] data;
   } exp_t;

   logic clk;
   logic resetn;
   int   vectors     = 0;
   int   miscompares = 0;
   int   cycleCnt    = 0;
   int   busyMode    = 0;
   exp_t sbQ[$];
   logic [8:0] reqQ[NUM_REQ][$];

   uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .PAYLOAD_BITS(PB)) bus();

   uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .PAYLOAD_BITS(PB)) dut (
      .i_clk    (clk),
      .i_resetn (resetn),
      .bus      (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cycleCnt++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
      end
   endtask

   task automatic applyStimulus(input int id, input logic [7:0] data, input logic last);
      reqQ[id].push_back({last, data});
   endtask

   task automatic expectByte(input int id, input logic [7:0] data);
      exp_t e;
      e.id   = id;
      e.data = data;
      sbQ.push_back(e);
   endtask

   task automatic applyReset();
      @(negedge clk);
      resetn = 1'b0;
      #1;
      checkOutput("rstReady", 32'(bus.req_ready), 0);
      checkOutput("rstEn", 32'(bus.uart_tx_en), 0);
      checkOutput("rstData", 32'(bus.uart_tx_data), 0);
      checkOutput("rstGrant", 32'(bus.grant_id), 0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic waitDrain(input string tag, input int budget);
      int n;
      n = 0;
      while (sbQ.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, sbQ.size(), 0);
      if (sbQ.size() != 0) begin
         sbQ.delete();
         for (int i = 0; i < NUM_REQ; i++) reqQ[i].delete();
         bus.req_valid = '0;
      end
      repeat (BUSY_CYC + 4) @(negedge clk);
   endtask

   // Requesters: hold valid/data until the accept cycle, then present the next queued byte.
   initial begin
      logic [NUM_REQ-1:0] acc;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      forever begin
         @(negedge clk);
         acc = bus.req_valid & bus.req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i]) begin
               void'(reqQ[i].pop_front());
               bus.req_valid[i] = 1'b0;
            end
            if (!bus.req_valid[i] && reqQ[i].size() > 0) begin
               bus.req_data[i*PB +: PB] = reqQ[i][0][7:0];
               bus.req_last[i]          = reqQ[i][0][8];
               bus.req_valid[i]         = 1'b1;
            end
         end
      end
   end

   // uart_tx stand-in: 0 = acknowledges strobes, 1 = stuck busy, 2 = ignores strobes.
   initial begin
      bus.uart_tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (busyMode == 1) begin
            bus.uart_tx_busy = 1'b1;
         end else if (busyMode == 2) begin
            bus.uart_tx_busy = 1'b0;
         end else if (bus.uart_tx_en) begin
            @(posedge clk);
            #1 bus.uart_tx_busy = 1'b1;
            repeat (BUSY_CYC) @(posedge clk);
            #1 bus.uart_tx_busy = 1'b0;
         end else begin
            bus.uart_tx_busy = 1'b0;
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (resetn) begin
            if (|bus.req_ready) begin
               if (sbQ.size() > 0) checkOutput("readyId", 32'(bus.req_ready), 32'(1) << sbQ[0].id);
               else checkOutput("readyWithoutGrant", 32'(bus.req_ready), 0);
            end
            if (bus.uart_tx_en) begin
               checkOutput("enBusyOverlap", 32'(bus.uart_tx_busy), 0);
               if (sbQ.size() > 0) begin
                  e = sbQ.pop_front();
                  checkOutput("grantId", 32'(bus.grant_id), e.id);
                  checkOutput("txData", 32'(bus.uart_tx_data), 32'(e.data));
               end else begin
                  checkOutput("enWithoutGrant", 32'(bus.uart_tx_en), 0);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: run exceeded its time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int t0;
      int t1;
      int n;
      resetn = 1'b0;

      // Round robin from reset: pointer starts at NUM_REQ-1, so requester 0 goes first.
      applyReset();
      applyStimulus(0, 8'h10, 1'b1);
      applyStimulus(0, 8'h11, 1'b1);
      applyStimulus(1, 8'h20, 1'b1);
      applyStimulus(1, 8'h21, 1'b1);
      applyStimulus(2, 8'h30, 1'b1);
      applyStimulus(3, 8'h40, 1'b1);
      expectByte(0, 8'h10);
      expectByte(1, 8'h20);
      expectByte(2, 8'h30);
      expectByte(3, 8'h40);
      expectByte(0, 8'h11);
      expectByte(1, 8'h21);
      waitDrain("t2Drain", 300);

      // Single requester latency: ready at t+1, strobe at t+2.
      applyReset();
      applyStimulus(2, 8'hA5, 1'b1);
      expectByte(2, 8'hA5);
      @(negedge clk);
      checkOutput("t1ReadyEarly", 32'(bus.req_ready), 0);
      @(negedge clk);
      checkOutput("t1Ready", 32'(bus.req_ready), 32'b0100);
      checkOutput("t1GrantId", 32'(bus.grant_id), 2);
      checkOutput("t1EnEarly", 32'(bus.uart_tx_en), 0);
      @(negedge clk);
      checkOutput("t1En", 32'(bus.uart_tx_en), 1);
      checkOutput("t1Data", 32'(bus.uart_tx_data), 32'hA5);
      checkOutput("t1ReadyPulse", 32'(bus.req_ready), 0);
      @(negedge clk);
      checkOutput("t1EnPulse", 32'(bus.uart_tx_en), 0);
      waitDrain("t1Drain", 100);

      // Busy held high blocks the grant until the first idle cycle after it falls.
      @(posedge clk);
      #1 busyMode = 1;
      @(negedge clk);
      applyStimulus(1, 8'h5C, 1'b1);
      expectByte(1, 8'h5C);
      repeat (6) begin
         @(negedge clk);
         checkOutput("t3HoldOff", 32'(bus.req_ready), 0);
      end
      @(posedge clk);
      #1 busyMode = 0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("t3GrantAfterBusy", 32'(bus.req_ready), 32'b0010);
      waitDrain("t3Drain", 100);

      // Reset while uart_tx is busy: outputs clear at once, arbitration restarts at 0.
      applyStimulus(1, 8'h77, 1'b1);
      expectByte(1, 8'h77);
      n = 0;
      while (!bus.uart_tx_busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("t4BusySeen", 32'(bus.uart_tx_busy), 1);
      repeat (2) @(negedge clk);
      resetn = 1'b0;
      #1;
      checkOutput("t4RstReady", 32'(bus.req_ready), 0);
      checkOutput("t4RstEn", 32'(bus.uart_tx_en), 0);
      checkOutput("t4RstData", 32'(bus.uart_tx_data), 0);
      checkOutput("t4RstGrant", 32'(bus.grant_id), 0);
      applyStimulus(0, 8'h0A, 1'b1);
      applyStimulus(3, 8'h3A, 1'b1);
      expectByte(0, 8'h0A);
      expectByte(3, 8'h3A);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      waitDrain("t4Drain", 200);

      // Strobe never acknowledged: back to idle after two cycles, next requester served.
      @(posedge clk);
      #1 busyMode = 2;
      @(negedge clk);
      applyStimulus(2, 8'h62, 1'b1);
      applyStimulus(3, 8'h63, 1'b1);
      expectByte(2, 8'h62);
      expectByte(3, 8'h63);
      n = 0;
      while (!bus.uart_tx_en && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("t6EnSeen", 32'(bus.uart_tx_en), 1);
      t0 = cycleCnt;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(|bus.req_ready) && n < 20);
      t1 = cycleCnt;
      checkOutput("t6ReturnGap", 32'(t1 - t0), 4);
      waitDrain("t6Drain", 100);
      @(posedge clk);
      #1 busyMode = 0;
      repeat (2) @(negedge clk);

      // Packet from requester 1 competing with requester 0; pointer left at 0 first.
      applyStimulus(0, 8'h01, 1'b1);
      expectByte(0, 8'h01);
      waitDrain("t5Prep", 100);
      applyStimulus(1, 8'hB1, 1'b0);
      applyStimulus(1, 8'hB2, 1'b0);
      applyStimulus(1, 8'hB3, 1'b1);
      applyStimulus(0, 8'hC1, 1'b1);
      applyStimulus(0, 8'hC2, 1'b1);
`ifdef UART_TX_ARBITER_LOCK_EN
      expectByte(1, 8'hB1);
      expectByte(1, 8'hB2);
      expectByte(1, 8'hB3);
      expectByte(0, 8'hC1);
      expectByte(0, 8'hC2);
`else
      expectByte(1, 8'hB1);
      expectByte(0, 8'hC1);
      expectByte(1, 8'hB2);
      expectByte(0, 8'hC2);
      expectByte(1, 8'hB3);
`endif
      waitDrain("t5Drain", 300);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
